// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates raster timing for a VGA-style display. A horizontal pixel
//   counter (x) and a vertical line counter (y) advance one pixel on every
//   clock edge where the pixel tick 'enable' is high. Sync, blanking and
//   start-of-line/frame strobes are decoded from the *next* counter values
//   and registered on the same edge as the counters. As a result, every
//   output lines up with the x/y it describes, with no pipeline skew.
//
// Parameters:
//   H_ACTIVE, H_FP, H_SYNC, H_BP : horizontal timing in pixels
//   V_ACTIVE, V_FP, V_SYNC, V_BP : vertical timing in lines
//   SYNC_POL                     : asserted level of h_sync / v_sync
//   Both H_TOTAL and V_TOTAL must be <= 1024 (10-bit counters).
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   pixel tick; timing advances only when high
//   x            out  horizontal count, 0..H_TOTAL-1
//   y            out  vertical count, 0..V_TOTAL-1
//   frame_active out  high inside the visible area
//   h_sync       out  horizontal sync, SYNC_POL during the pulse
//   v_sync       out  vertical sync, SYNC_POL during the pulse
//   line_start   out  one-clk pulse on entry to x=0
//   frame_start  out  one-clk pulse on entry to (0,0)
//   frame_count  out  completed frames, modulo 1024
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  output logic       h_sync,
  output logic       v_sync,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Every boundary is precomputed at the counter width, so all of the
  // comparisons below are between 10-bit quantities.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic [9:0] frame_count_next;
  logic       x_wrap;
  logic       frame_wrap;
  logic       h_in_sync;
  logic       v_in_sync;
  logic       active_next;

  // Next-position arithmetic: this is where the counters would go if the
  // current edge is a pixel tick. The decode is done on these next values,
  // which lets the registered outputs describe the same pixel as x/y.
  always_comb begin
    x_next           = x + 10'd1;
    y_next           = y;
    frame_count_next = frame_count;
    x_wrap           = 1'b0;
    frame_wrap       = 1'b0;
    if (x == H_LAST) begin
      x_next = '0;
      x_wrap = 1'b1;
      if (y == V_LAST) begin
        y_next           = '0;
        frame_wrap       = 1'b1;
        frame_count_next = frame_count + 10'd1;
      end else begin
        y_next = y + 10'd1;
      end
    end
  end

  // Region decode of the next position.
  always_comb begin
    h_in_sync   = (x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST);
    v_in_sync   = (y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST);
    active_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // State and output registers. Without a tick, everything holds except the
  // strobes, which only ever last the single clock after the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      frame_count  <= '0;
      frame_active <= 1'b0;
      h_sync       <= ~SYNC_POL;
      v_sync       <= ~SYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (enable) begin
      x            <= x_next;
      y            <= y_next;
      frame_count  <= frame_count_next;
      frame_active <= active_next;
      h_sync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      v_sync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
      line_start   <= x_wrap;
      frame_start  <= frame_wrap;
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. It uses three instances:
//   dut_m : small raster (16 x 11), active-low sync, main checking target
//   dut_d : default 800 x 525 timing, used for a single line sweep
//   dut_t : tiny raster (4 x 4), active-high sync, for frame_count wrap
// The main instance is checked against a reference that counts total
// pixel ticks since reset and derives the position with div/mod.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Small raster for the main instance
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 11

  logic clk;
  logic rst;
  logic en_m, en_d, en_t;

  logic [9:0] x_m, y_m, fc_m;
  logic       fa_m, hs_m, vs_m, ls_m, fs_m;
  logic [9:0] x_d, y_d, fc_d;
  logic       fa_d, hs_d, vs_d, ls_d, fs_d;
  logic [9:0] x_t, y_t, fc_t;
  logic       fa_t, hs_t, vs_t, ls_t, fs_t;

  int vectors;
  int miscompares;

  // Reference model state: pixel ticks since reset, and whether the most
  // recent edge carried a tick.
  int ticks;
  bit last_en;

  typedef struct {
    int   run;
    logic en;
    int   ex;
    int   ey;
    logic efa;
    logic ehs;
    logic evs;
    logic els;
    logic efs;
    int   efc;
  } vec_t;

  vec_t tbl[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut_m (
    .clk(clk), .rst(rst), .enable(en_m),
    .x(x_m), .y(y_m), .frame_active(fa_m),
    .h_sync(hs_m), .v_sync(vs_m),
    .line_start(ls_m), .frame_start(fs_m), .frame_count(fc_m)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .enable(en_d),
    .x(x_d), .y(y_d), .frame_active(fa_d),
    .h_sync(hs_d), .v_sync(vs_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_t (
    .clk(clk), .rst(rst), .enable(en_t),
    .x(x_t), .y(y_t), .frame_active(fa_t),
    .h_sync(hs_t), .v_sync(vs_t),
    .line_start(ls_t), .frame_start(fs_t), .frame_count(fc_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock of the main instance and advance the model.
  task automatic applyStimulus(input logic en);
    en_m = en;
    @(posedge clk);
    if (en) ticks++;
    last_en = en;
    @(negedge clk);
  endtask

  task automatic stepD(input logic en);
    en_d = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepT(input logic en);
    en_t = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic modelReset();
    ticks   = 0;
    last_en = 1'b0;
  endtask

  task automatic doReset();
    en_m = 1'b0;
    en_d = 1'b0;
    en_t = 1'b0;
    rst  = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare the main instance against the tick-count reference.
  task automatic checkModel(input string tag);
    int  ex, ey, efc;
    bit  efa, ehs, evs, els, efs;
    ex  = ticks % HT;
    ey  = (ticks / HT) % VT;
    efc = (ticks / (HT * VT)) % 1024;
    if (ticks == 0) begin
      efa = 1'b0; ehs = 1'b1; evs = 1'b1; els = 1'b0; efs = 1'b0;
    end else begin
      efa = (ex < HA) && (ey < VA);
      ehs = !((ex >= HA + HF) && (ex <= HA + HF + HS - 1));
      evs = !((ey >= VA + VF) && (ey <= VA + VF + VS - 1));
      els = last_en && (ex == 0);
      efs = last_en && (ex == 0) && (ey == 0);
    end
    checkOutput({tag, "_x"},  int'(x_m),  ex);
    checkOutput({tag, "_y"},  int'(y_m),  ey);
    checkOutput({tag, "_fc"}, int'(fc_m), efc);
    checkOutput({tag, "_fa"}, int'(fa_m), int'(efa));
    checkOutput({tag, "_hs"}, int'(hs_m), int'(ehs));
    checkOutput({tag, "_vs"}, int'(vs_m), int'(evs));
    checkOutput({tag, "_ls"}, int'(ls_m), int'(els));
    checkOutput({tag, "_fs"}, int'(fs_m), int'(efs));
  endtask

  initial begin
    int hs_low, first_low, last_low, fa_cnt;

    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    en_m = 1'b0;
    en_d = 1'b0;
    en_t = 1'b0;
    modelReset();

    // Hand-derived vectors for the 16 x 11 raster, from reset:
    // run, en, x, y, fa, hs, vs, ls, fs, fc
    tbl.push_back('{1,  1'b1,  1,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{9,  1'b1, 10,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{2,  1'b1, 12,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1,  1'b1, 13,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{3,  1'b1,  0,  1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{1,  1'b1,  1,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{95, 1'b1,  0,  7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{15, 1'b1, 15,  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{16, 1'b1, 15,  8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1,  1'b1,  0,  9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{31, 1'b1, 15, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1,  1'b1,  0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1});
    tbl.push_back('{2,  1'b0,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{1,  1'b1,  1,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1});

    // Reset state, sampled while rst is still high.
    @(negedge clk);
    checkOutput("rst_x",   int'(x_m),  0);
    checkOutput("rst_y",   int'(y_m),  0);
    checkOutput("rst_fa",  int'(fa_m), 0);
    checkOutput("rst_hs",  int'(hs_m), 1);
    checkOutput("rst_vs",  int'(vs_m), 1);
    checkOutput("rst_ls",  int'(ls_m), 0);
    checkOutput("rst_fs",  int'(fs_m), 0);
    checkOutput("rst_fc",  int'(fc_m), 0);
    checkOutput("rst_t_hs", int'(hs_t), 0);
    checkOutput("rst_t_vs", int'(vs_t), 0);
    doReset();

    // Table-driven section.
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].run; r++) applyStimulus(tbl[i].en);
      checkOutput($sformatf("tbl%0d_x", i),  int'(x_m),  tbl[i].ex);
      checkOutput($sformatf("tbl%0d_y", i),  int'(y_m),  tbl[i].ey);
      checkOutput($sformatf("tbl%0d_fa", i), int'(fa_m), int'(tbl[i].efa));
      checkOutput($sformatf("tbl%0d_hs", i), int'(hs_m), int'(tbl[i].ehs));
      checkOutput($sformatf("tbl%0d_vs", i), int'(vs_m), int'(tbl[i].evs));
      checkOutput($sformatf("tbl%0d_ls", i), int'(ls_m), int'(tbl[i].els));
      checkOutput($sformatf("tbl%0d_fs", i), int'(fs_m), int'(tbl[i].efs));
      checkOutput($sformatf("tbl%0d_fc", i), int'(fc_m), tbl[i].efc);
    end

    // Enable pattern 1,0,0,1 around the last pixel of the frame.
    doReset();
    for (int r = 0; r < HT * VT - 1; r++) applyStimulus(1'b1);
    checkOutput("tog_x_last", int'(x_m), HT - 1);
    checkOutput("tog_y_last", int'(y_m), VT - 1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("tog_hold_x",  int'(x_m),  HT - 1);
    checkOutput("tog_hold_y",  int'(y_m),  VT - 1);
    checkOutput("tog_hold_fs", int'(fs_m), 0);
    applyStimulus(1'b1);
    checkOutput("tog_wrap_x",  int'(x_m),  0);
    checkOutput("tog_wrap_y",  int'(y_m),  0);
    checkOutput("tog_wrap_fs", int'(fs_m), 1);
    checkOutput("tog_wrap_ls", int'(ls_m), 1);
    checkOutput("tog_wrap_fc", int'(fc_m), 1);
    applyStimulus(1'b0);
    checkOutput("tog_after_fs", int'(fs_m), 0);
    checkOutput("tog_after_x",  int'(x_m),  0);

    // Asynchronous reset in the middle of both sync pulses.
    doReset();
    for (int r = 0; r < 8 * HT + 11; r++) applyStimulus(1'b1);
    checkOutput("ar_pre_hs", int'(hs_m), 0);
    checkOutput("ar_pre_vs", int'(vs_m), 0);
    en_m = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("ar_x",  int'(x_m),  0);
    checkOutput("ar_y",  int'(y_m),  0);
    checkOutput("ar_fa", int'(fa_m), 0);
    checkOutput("ar_hs", int'(hs_m), 1);
    checkOutput("ar_vs", int'(vs_m), 1);
    checkOutput("ar_fc", int'(fc_m), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1);
    checkOutput("ar_resume_x",  int'(x_m),  1);
    checkOutput("ar_resume_y",  int'(y_m),  0);
    checkOutput("ar_resume_fa", int'(fa_m), 1);
    checkOutput("ar_resume_ls", int'(ls_m), 0);
    checkOutput("ar_resume_fs", int'(fs_m), 0);

    // Randomized enables and occasional mid-cycle resets against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0);
      checkModel("rnd");
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkModel("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Default timing: one full line sweep.
    doReset();
    hs_low    = 0;
    first_low = -1;
    last_low  = -1;
    fa_cnt    = 0;
    for (int r = 1; r < 800; r++) begin
      stepD(1'b1);
      if (hs_d == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(x_d);
        last_low = int'(x_d);
      end
      if (fa_d) fa_cnt++;
      if (ls_d) checkOutput("def_ls_early", int'(x_d), 0);
    end
    checkOutput("def_hs_low_cnt",   hs_low,    96);
    checkOutput("def_hs_first",     first_low, 656);
    checkOutput("def_hs_last",      last_low,  751);
    checkOutput("def_fa_cnt",       fa_cnt,    639);
    stepD(1'b1);
    checkOutput("def_line_x",  int'(x_d),  0);
    checkOutput("def_line_y",  int'(y_d),  1);
    checkOutput("def_line_ls", int'(ls_d), 1);
    checkOutput("def_line_fs", int'(fs_d), 0);
    checkOutput("def_line_fa", int'(fa_d), 1);
    stepD(1'b1);
    checkOutput("def_line_ls_off", int'(ls_d), 0);
    checkOutput("def_line_x1",     int'(x_d),  1);

    // Tiny active-high raster: inverted sync levels and frame_count wrap.
    doReset();
    stepT(1'b1);
    checkOutput("tiny_hs_x1", int'(hs_t), 0);
    stepT(1'b1);
    checkOutput("tiny_hs_x2", int'(hs_t), 1);
    checkOutput("tiny_vs_y0", int'(vs_t), 0);
    for (int r = 2; r < 8; r++) stepT(1'b1);
    checkOutput("tiny_vs_y2", int'(vs_t), 1);
    checkOutput("tiny_hs_x0", int'(hs_t), 0);
    for (int r = 8; r < 1023 * 16; r++) stepT(1'b1);
    checkOutput("tiny_fc_1023", int'(fc_t), 1023);
    checkOutput("tiny_fs_1023", int'(fs_t), 1);
    for (int r = 0; r < 16; r++) stepT(1'b1);
    checkOutput("tiny_fc_wrap", int'(fc_t), 0);
    checkOutput("tiny_fs_wrap", int'(fs_t), 1);
    checkOutput("tiny_x_wrap",  int'(x_t),  0);
    checkOutput("tiny_y_wrap",  int'(y_t),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels; H_TOTAL = sum of the four = 800.
REQ-005 Parameter V_ACTIVE, default 480: visible lines.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines; V_TOTAL = 525.
REQ-009 Parameter SYNC_POL, default 0: asserted level of h_sync/v_sync (0 = active-low).
REQ-010 clk  input  1  the single clock; all state changes on its rising edge.
REQ-011 rst  input  1  reset, asynchronous, active-high.
REQ-012 enable  input  1  pixel tick; the timing advances one pixel only on clk edges where enable=1.
REQ-013 x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-014 y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-015 frame_active  output  1  high when x<H_ACTIVE and y<V_ACTIVE.
REQ-016 h_sync  output  1  horizontal sync, at level SYNC_POL during the pulse.
REQ-017 v_sync  output  1  vertical sync, at level SYNC_POL during the pulse.
REQ-018 line_start  output  1  one-clk pulse on entry to x=0.
REQ-019 frame_start  output  1  one-clk pulse on entry to (x,y)=(0,0).
REQ-020 frame_count  output  10  count of completed frames, wrapping modulo 1024.

Function
REQ-021 On each clk edge with enable=1: x increments; at x=H_TOTAL-1, x wraps to 0 and y increments.
REQ-022 On the x wrap with y=V_TOTAL-1, y wraps to 0 and frame_count increments, wrapping 1023->0.
REQ-023 With enable=0, all state holds, except that line_start and frame_start clear to 0.
REQ-024 Every output is a register that is updated on the same edge as the counters and reflects the new (x,y), giving zero cycles of skew between x/y and the decoded outputs.
REQ-025 h_sync = SYNC_POL iff H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 at defaults); otherwise it is !SYNC_POL.
REQ-026 v_sync = SYNC_POL iff V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 at defaults), over all x of those lines; otherwise it is !SYNC_POL.
REQ-027 line_start is 1 for exactly one clk after an enabled edge that moves x from H_TOTAL-1 to 0, and is 0 otherwise.
REQ-028 frame_start is 1 for exactly one clk after an enabled edge that moves (x,y) to (0,0); line_start is also 1 on that cycle.
REQ-029 frame_count updates on the same edge at which frame_start is set.
REQ-030 Count arithmetic is 10-bit unsigned, and the parameters are required to satisfy H_TOTAL<=1024 and V_TOTAL<=1024.
REQ-031 enable held continuously high gives a fixed period: frame_start every H_TOTAL*V_TOTAL clks (420000 at defaults) and line_start every H_TOTAL clks.

Reset
REQ-032 While rst=1, outputs are immediately (asynchronously) x=0, y=0, frame_active=0, h_sync=v_sync=!SYNC_POL, line_start=0, frame_start=0, frame_count=0.
REQ-033 After rst falls, the first enabled edge moves to (1,0), with frame_active=1, and no frame_start or line_start pulse is issued for (0,0) of the first frame.
REQ-034 Asserting rst mid-frame (including mid-sync-pulse) abandons the frame immediately, and the state is identical to REQ-032.

Verification
REQ-035 Reset, then 800 enabled clks -> x returns to 0, y=1, line_start=1 for exactly that one clk, frame_start=0.
REQ-036 Run 420000 enabled clks from reset -> (x,y)=(0,0), frame_start=1 for one clk, frame_count=1; a further 420000 clks -> frame_count=2.
REQ-037 Sweep line 0 -> h_sync low exactly for x=656..751 (96 clks) and frame_active high for x=0..639; sweep line 490 -> v_sync low for the whole line and on line 491, frame_active=0.
REQ-038 enable toggling 1,0,0,1 at x=799,y=524 -> state holds during the enable=0 clks, wraps to (0,0) on the next enable=1, and frame_start is high one clk only.
REQ-039 Force frame_count to 1023 via 1023 frames -> the next wrap gives frame_count=0; SYNC_POL=1 build -> sync levels are inverted and reset level is 0.
REQ-040 Assert rst asynchronously (mid-clk) at (700,491) -> outputs match REQ-032 before the next clk edge, and the run resumes per REQ-033.
